uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Buffered 8N1 UART transmitter: the transmit-side counterpart to the board's
//   RS232 receive path. Bytes from on-chip logic are queued in a small FIFO and
//   serialised on RS232_TX_o at CLK_i/CLOCK_DIVIDE baud. Frames go out
//   back-to-back while the FIFO holds data.
// PARAMETERS
//   CLOCK_DIVIDE     312  CLK_i cycles per bit (>= 2)
//   FIFO_DEPTH_LOG2  4    FIFO depth = 2**FIFO_DEPTH_LOG2 bytes
// PORTS
//   CLK_i         in   1                  single system clock, all logic on rising edge
//   RST_i         in   1                  synchronous reset, active-high
//   TX_DATA_i     in   8                  byte to enqueue
//   TX_VALID_i    in   1                  TX_DATA_i valid
//   TX_READY_o    out  1                  FIFO can accept; byte taken on VALID&&READY edge
//   RS232_TX_o    out  1                  serial line, idle high, registered
//   BUSY_o        out  1                  frame in flight or FIFO non-empty
//   FIFO_LEVEL_o  out  FIFO_DEPTH_LOG2+1  bytes stored (excludes byte being shifted)
// BEHAVIOUR
//   Reset (RST_i high at edge): RS232_TX_o=1, BUSY_o=0, FIFO_LEVEL_o=0, FSM=IDLE,
//     pointers/counters=0. TX_READY_o = !full && !RST_i (combinational).
//   Reset mid-frame: frame aborted, line high next cycle, queued bytes discarded.
//   FIFO: push on VALID&&READY. Pop only by FSM in IDLE when level!=0.
//     Full: READY low; a push is refused even if a pop occurs in the same cycle.
//     Empty: a push and a pop never coincide (pop needs registered level!=0).
//     Pointers wrap modulo depth; level = wr-rd, width FIFO_DEPTH_LOG2+1.
//   FSM states, baud counter 0..CLOCK_DIVIDE-1, bit index 0..7:
//     IDLE : line=1. If level!=0: pop, load shift reg, line<=0, counter<=0, ->START.
//     START: hold 0 for CLOCK_DIVIDE cycles, then line<=bit0, ->DATA.
//     DATA : each bit held CLOCK_DIVIDE cycles, LSB first; after bit7, line<=1, ->STOP.
//     STOP : hold 1 for CLOCK_DIVIDE cycles. At the end: if level!=0, pop and go
//            straight to START (no idle gap), else ->IDLE.
//   Frame length exactly 10*CLOCK_DIVIDE cycles.
//   Latency: byte accepted at edge N into an empty, idle block ->
//     RS232_TX_o falls at edge N+2 (N+1 level update, N+2 pop).
//   BUSY_o registered: 1 whenever state!=IDLE or level!=0.
//   Stop-bit boundary: pop and push in the same cycle -> level unchanged.
//   TX_DATA_i ignored when not accepted. No parity, no flow-control inputs.
// TESTING (CLOCK_DIVIDE=4, FIFO_DEPTH_LOG2=4)
//   1 Reset -> RS232_TX_o=1, TX_READY_o=1 after release, FIFO_LEVEL_o=0, BUSY_o=0.
//   2 Push 0xA5 -> line 0x4, then 1,0,1,0,0,1,0,1 each x4, then 1x4 (40 cycles);
//     BUSY_o drops the cycle after the stop bit ends.
//   3 Push 0x00 then 0xFF on consecutive cycles -> 80 contiguous frame cycles,
//     stop bit of frame 1 followed directly by start of frame 2.
//   4 Hold VALID with 20 bytes -> 17 accepted (1 popped + 16 stored), READY low,
//     then exactly one more accepted per completed frame; order preserved.
//   5 Assert RST_i at cycle 15 of a frame with 3 queued -> line 1 next cycle,
//     level 0; a following push of 0x3C transmits cleanly.
//   6 VALID high while full -> byte not stored, level stays 16, no corruption.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop serialiser.
// Frames run back-to-back while bytes remain queued.
module uart_tx_fifo #(
    parameter int CLOCK_DIVIDE    = 312,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     CLK_i,
    input  logic                     RST_i,
    input  logic [7:0]               TX_DATA_i,
    input  logic                     TX_VALID_i,
    output logic                     TX_READY_o,
    output logic                     RS232_TX_o,
    output logic                     BUSY_o,
    output logic [FIFO_DEPTH_LOG2:0] FIFO_LEVEL_o
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W = FIFO_DEPTH_LOG2 + 1;
    localparam int CNT_W = $clog2(CLOCK_DIVIDE);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_W  = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCK_DIVIDE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [DEPTH];
    logic [7:0]       rd_data_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] level_reg;
    logic [PTR_W-1:0] ptr_diff;
    logic             full;
    logic             push;
    logic             pop;

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [2:0]       bit_reg,    bit_next;
    logic [7:0]       shift_reg,  shift_next;
    logic             line_reg,   line_next;
    logic             busy_reg;

    assign ptr_diff   = wr_ptr_reg - rd_ptr_reg;
    assign full       = (ptr_diff == DEPTH_W);
    assign TX_READY_o = !full && !RST_i;
    assign push       = TX_VALID_i && TX_READY_o;

    // The head byte is prefetched every cycle; a pop only happens once the
    // registered level shows data, so the prefetch is always current by then.
    always_ff @(posedge CLK_i) begin
        if (push) begin
            mem[wr_ptr_reg[FIFO_DEPTH_LOG2-1:0]] <= TX_DATA_i;
        end
        rd_data_reg <= mem[rd_ptr_reg[FIFO_DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            level_reg <= ptr_diff;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            line_reg  <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            line_reg  <= line_next;
            busy_reg  <= (state_reg != IDLE) || (level_reg != '0);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        line_next  = line_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                line_next = 1'b1;
                if (level_reg != '0) begin
                    pop        = 1'b1;
                    shift_next = rd_data_reg;
                    line_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    line_next  = shift_reg[0];
                    state_next = DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
                        line_next  = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        line_next  = shift_reg[1];
                        shift_next = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (level_reg != '0) begin
                        pop        = 1'b1;
                        shift_next = rd_data_reg;
                        line_next  = 1'b0;
                        state_next = START;
                    end else begin
                        line_next  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign RS232_TX_o   = line_reg;
    assign BUSY_o       = busy_reg;
    assign FIFO_LEVEL_o = level_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, all outputs
// compared every cycle against a frame-timing reference model.
module tb_uart_tx_fifo;
    localparam int CD    = 4;
    localparam int LOG2  = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CD;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_line;
    logic        busy;
    logic [LOG2:0] level;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLOCK_DIVIDE(CD), .FIFO_DEPTH_LOG2(LOG2)) dut (
        .CLK_i        (clk),
        .RST_i        (rst),
        .TX_DATA_i    (tx_data),
        .TX_VALID_i   (tx_valid),
        .TX_READY_o   (tx_ready),
        .RS232_TX_o   (tx_line),
        .BUSY_o       (busy),
        .FIFO_LEVEL_o (level)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs != expv) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference model: bytes queued, a frame timer, and the one-cycle-late
    // level/busy views the outside world sees.
    logic [7:0] q[$];
    int         m_lvl_reg  = 0;
    int         m_busy     = 0;
    int         m_active   = 0;
    int         m_t        = 0;
    logic [7:0] m_byte     = 8'h00;
    int         size_before;
    int         old_lvl;
    int         old_active;

    always @(posedge clk) begin
        size_before = q.size();
        old_lvl     = m_lvl_reg;
        old_active  = m_active;
        if (rst) begin
            q.delete();
            m_lvl_reg = 0;
            m_busy    = 0;
            m_active  = 0;
            m_t       = 0;
        end else begin
            m_busy    = (old_active != 0 || old_lvl != 0) ? 1 : 0;
            m_lvl_reg = size_before;
            if (old_active != 0) begin
                m_t++;
                if (m_t == FRAME) begin
                    if (old_lvl != 0) begin
                        m_byte = q.pop_front();
                        m_t    = 0;
                    end else begin
                        m_active = 0;
                    end
                end
            end else if (old_lvl != 0) begin
                m_byte   = q.pop_front();
                m_t      = 0;
                m_active = 1;
            end
            if (tx_valid && size_before < DEPTH) q.push_back(tx_data);
        end
    end

    function automatic int exp_line();
        int idx;
        if (m_active == 0) return 1;
        idx = m_t / CD;
        if (idx == 0) return 0;
        if (idx == 9) return 1;
        return int'(m_byte[idx-1]);
    endfunction

    task automatic cycle();
        @(negedge clk);
        check("line",  int'(tx_line),  exp_line());
        check("level", int'(level),    m_lvl_reg);
        check("busy",  int'(busy),     m_busy);
        check("ready", int'(tx_ready), (q.size() < DEPTH && !rst) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        tx_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        cycle();
        tx_valid = 1'b0;
    endtask

    // Hold VALID with random bytes until n have been taken; reports how many
    // had been taken when READY first dropped.
    task automatic stream(input int n, output int acc_at_full);
        int idx    = 0;
        int budget = 3000;
        bit will_take;
        bit seen_full = 1'b0;
        acc_at_full = -1;
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        while (idx < n && budget > 0) begin
            will_take = tx_valid && tx_ready;
            cycle();
            budget--;
            if (will_take) begin
                idx++;
                tx_data = 8'($urandom);
            end
            if (!seen_full && !tx_ready) begin
                seen_full   = 1'b1;
                acc_at_full = idx;
            end
        end
        tx_valid = 1'b0;
        if (budget == 0) check("stream_timeout", 0, 1);
    endtask

    task automatic window(input int n, output int busy_cnt, output int low_cnt);
        busy_cnt = 0;
        low_cnt  = 0;
        repeat (n) begin
            cycle();
            if (busy)     busy_cnt++;
            if (!tx_line) low_cnt++;
        end
    endtask

    initial begin
        int bcnt;
        int lcnt;
        int acc;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cycle();
        check("rst_ready", int'(tx_ready), 1);
        check("rst_line",  int'(tx_line),  1);
        check("rst_level", int'(level),    0);
        check("rst_busy",  int'(busy),     0);
        $display("reset released");

        push_byte(8'hA5);
        window(60, bcnt, lcnt);
        check("a5_busy_cycles", bcnt, 41);
        check("a5_low_cycles",  lcnt, 20);
        $display("frame 0xA5: busy %0d low %0d", bcnt, lcnt);

        tx_valid = 1'b1;
        tx_data  = 8'h00;
        cycle();
        tx_data  = 8'hFF;
        cycle();
        tx_valid = 1'b0;
        window(100, bcnt, lcnt);
        check("b2b_busy_cycles", bcnt, 81);
        check("b2b_low_cycles",  lcnt, 40);
        $display("frames 0x00,0xFF: busy %0d low %0d", bcnt, lcnt);

        stream(20, acc);
        check("fill_accepted", acc, 17);
        $display("stream 20 bytes: %0d taken when ready dropped", acc);
        idle(850);

        stream(4, acc);
        repeat (13) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_line",  int'(tx_line), 1);
        check("midrst_level", int'(level),   0);
        push_byte(8'h3C);
        window(50, bcnt, lcnt);
        check("post_rst_low_cycles", lcnt, 20);
        $display("mid-frame reset then 0x3C: low %0d", lcnt);

        stream(17, acc);
        check("full_accepted", acc, 17);
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        repeat (8) begin
            cycle();
            check("full_level", int'(level),    16);
            check("full_ready", int'(tx_ready), 0);
        end
        tx_valid = 1'b0;
        $display("valid while full: level %0d", level);
        idle(700);

        for (int blk = 0; blk < 6; blk++) begin
            int rate = $urandom_range(1, 12);
            for (int c = 0; c < 500; c++) begin
                tx_valid = ($urandom_range(0, rate) == 0);
                tx_data  = 8'($urandom);
                rst      = ($urandom_range(0, 999) == 0);
                cycle();
            end
            rst = 1'b0;
            $display("random block %0d rate 1/%0d done", blk, rate + 1);
        end
        idle(700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
